output_ram_writer: RTL and testbench
====================================

OUTPUT_RAM_WRITER -- requirements
Module: output_ram_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 128, pixels per row.
REQ-002 SHALL have parameter IMG_H, default 128, rows per frame.
REQ-003 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port iStart  input  1  arms capture of one frame.
REQ-007 SHALL have port iValid  input  1  iData carries a pixel.
REQ-008 SHALL have port iData  input  PIX_W  pixel value, raster order.
REQ-009 SHALL have port oReady  output  1  writer accepts a pixel this cycle.
REQ-010 SHALL have port iRdCol  input  7  read column.
REQ-011 SHALL have port iRdRow  input  7  read row.
REQ-012 SHALL have port oRdData  output  PIX_W  stored pixel at (iRdCol, iRdRow).
REQ-013 SHALL have port oCol  output  7  next write column.
REQ-014 SHALL have port oRow  output  7  next write row.
REQ-015 SHALL have port oBusy  output  1  frame capture in progress.
REQ-016 SHALL have port oDone  output  1  one-cycle frame-complete pulse.
REQ-017 SHALL have port oDropped  output  1  sticky flag: a pixel was offered while not ready.

Function
REQ-018 SHALL implement the FSM states IDLE, WRITE and DONE.
REQ-019 SHALL go from IDLE to WRITE on iStart=1 and clear oCol and oRow to 0 and oDropped to 0 in that transition.
REQ-020 SHALL drive oReady=1 and oBusy=1 only in WRITE.
REQ-021 SHALL treat a transfer as iValid=1 and oReady=1 in the same cycle, writing iData to address {oRow, oCol} (14 bits, row-major).
REQ-022 SHALL advance oCol by 1 per transfer, wrap oCol from IMG_W-1 to 0 and increment oRow on that wrap.
REQ-023 SHALL go from WRITE to DONE on the transfer at (IMG_W-1, IMG_H-1), and leave oCol and oRow at 0.
REQ-024 SHALL assert oDone=1 for exactly the one cycle in DONE, then return to IDLE.
REQ-025 SHALL ignore iStart in WRITE and DONE; the frame is not restarted.
REQ-026 SHALL discard iValid=1 outside WRITE without a memory write, and set oDropped to 1 until the next accepted iStart.
REQ-027 SHALL hold oCol and oRow when iValid=0 in WRITE; gaps of any length are allowed.
REQ-028 SHALL register oRdData with 1-cycle latency from iRdCol/iRdRow; the read port is independent of the FSM.
REQ-029 SHALL return the old content (read-first) when reading and writing the same address in the same cycle.
REQ-030 SHALL accept iStart in the DONE cycle only at the next IDLE cycle; back-to-back frames need one idle cycle.

Reset
REQ-031 SHALL, while reset_n=0, force state IDLE, oCol=0, oRow=0, oReady=0, oBusy=0, oDone=0, oDropped=0 and oRdData=0, asynchronously.
REQ-032 SHALL abandon a frame on reset mid-operation and SHALL NOT clear the memory contents; pixels already written persist.
REQ-033 SHALL require iStart after reset release before capture; it does not auto-arm.

Structure
REQ-034 SHALL take IMG_W, IMG_H, PIX_W, ADDR_W=14 and the FSM state encoding from the shared package image_pkg.
REQ-035 SHALL instantiate one sub-module, output_ram: a simple dual-port IMG_W*IMG_H x PIX_W RAM with a write port and a registered read port, inferable as block RAM.
REQ-036 SHALL contain counters, FSM and flags in output_ram_writer; output_ram holds no control logic.

Verification
REQ-037 SHALL cover full frame: iStart, then 16384 transfers of iData=(row+col)&8'hFF with iValid held 1 -> oDone pulses once, the cycle after the last transfer; readback at (5,3)=8'h08, at (127,127)=8'hFE.
REQ-038 SHALL cover gaps: iValid toggled 1/0 every cycle across row 0 -> oCol steps only on transfers; (127,0) wraps to oCol=0, oRow=1.
REQ-039 SHALL cover drop: iValid=1, iData=8'hAA in IDLE -> no write (address 0 keeps prior value), oDropped=1; next iStart -> oDropped=0.
REQ-040 SHALL cover reset mid-frame: reset_n=0 after 200 transfers -> IDLE, oBusy=0, oCol=oRow=0; readback of address 199 still returns the pixel written earlier.
REQ-041 SHALL cover read-during-write: read (10,0) in the same cycle as writing 8'h55 there over 8'h11 -> oRdData=8'h11 next cycle, 8'h55 on the following read.
REQ-042 SHALL cover iStart during WRITE at pixel 500 -> counters continue from 501; oDone pulses only after pixel 16383.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image geometry, address width and writer FSM encoding.
package image_pkg;

  localparam int IMG_W   = 128;
  localparam int IMG_H   = 128;
  localparam int PIX_W   = 8;
  localparam int ADDR_W  = 14;
  localparam int COORD_W = 7;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Row-major pixel address: row in the upper bits, column in the lower bits.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] row,
                                                 input logic [COORD_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/output_ram.sv
// Simple dual-port frame store: one write port, one registered read-first read port.
module output_ram #(
  parameter int PIX_W  = image_pkg::PIX_W,
  parameter int ADDR_W = image_pkg::ADDR_W,
  parameter int DEPTH  = image_pkg::IMG_W * image_pkg::IMG_H
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Separate read register samples the array before this edge's write lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/output_ram_writer.sv
// Captures one raster-order frame into output_ram on request; read port is free-running.
module output_ram_writer #(
  parameter int IMG_W = image_pkg::IMG_W,
  parameter int IMG_H = image_pkg::IMG_H,
  parameter int PIX_W = image_pkg::PIX_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          iStart,
  input  logic                          iValid,
  input  logic [PIX_W-1:0]              iData,
  output logic                          oReady,
  input  logic [image_pkg::COORD_W-1:0] iRdCol,
  input  logic [image_pkg::COORD_W-1:0] iRdRow,
  output logic [PIX_W-1:0]              oRdData,
  output logic [image_pkg::COORD_W-1:0] oCol,
  output logic [image_pkg::COORD_W-1:0] oRow,
  output logic                          oBusy,
  output logic                          oDone,
  output logic                          oDropped
);
  import image_pkg::*;

  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(IMG_H - 1);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic               dropped_q, dropped_d;
  logic               wr_en;

  assign wr_en = (state_q == ST_WRITE) && iValid;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    dropped_d = dropped_q;
    case (state_q)
      ST_IDLE: begin
        if (iStart) begin
          state_d   = ST_WRITE;
          col_d     = '0;
          row_d     = '0;
          dropped_d = 1'b0;
        end
      end
      ST_WRITE: begin
        if (iValid) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + COORD_W'(1);
            end
          end else begin
            col_d = col_q + COORD_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A pixel offered while not accepting is lost; remember that until the next start.
    if (iValid && (state_q != ST_WRITE)) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      dropped_q <= dropped_d;
    end
  end

  assign oReady   = (state_q == ST_WRITE);
  assign oBusy    = (state_q == ST_WRITE);
  assign oDone    = (state_q == ST_DONE);
  assign oDropped = dropped_q;
  assign oCol     = col_q;
  assign oRow     = row_q;

  output_ram #(
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W),
    .DEPTH (IMG_W * IMG_H)
  ) u_ram (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .we_i   (wr_en),
    .waddr_i(pix_addr(row_q, col_q)),
    .wdata_i(iData),
    .raddr_i(pix_addr(iRdRow, iRdCol)),
    .rdata_o(oRdData)
  );

endmodule

// File: tb/tb_output_ram_writer.sv
// Randomized frame-capture bench with a flat-array reference image.
module tb_output_ram_writer;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clock = 1'b0;
  logic       reset_n = 1'b1;
  logic       iStart = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'h00;
  logic       oReady;
  logic [6:0] iRdCol = 7'd0;
  logic [6:0] iRdRow = 7'd0;
  logic [7:0] oRdData;
  logic [6:0] oCol;
  logic [6:0] oRow;
  logic       oBusy;
  logic       oDone;
  logic       oDropped;

  logic [7:0] ref_mem [NPIX];
  int vectors = 0;
  int miscompares = 0;

  output_ram_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .iStart(iStart), .iValid(iValid), .iData(iData),
    .oReady(oReady), .iRdCol(iRdCol), .iRdRow(iRdRow), .oRdData(oRdData),
    .oCol(oCol), .oRow(oRow), .oBusy(oBusy), .oDone(oDone), .oDropped(oDropped)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic read_pix(input int col, input int row, output logic [7:0] d);
    iRdCol = 7'(col);
    iRdRow = 7'(row);
    tick();
    d = oRdData;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #2;
    vectors++;
    if ({oReady, oBusy, oDone, oDropped} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got rdy/busy/done/drop=%b want 0000", {oReady, oBusy, oDone, oDropped});
    end
    vectors++;
    if (oCol !== 7'd0 || oRow !== 7'd0 || oRdData !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_regs: got col=%0d row=%0d rd=%h want 0 0 00", oCol, oRow, oRdData);
    end
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_autoarm: got busy=%b want 0", oBusy);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_frame();
    logic [7:0] d;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    vectors++;
    if (oBusy !== 1'b1 || oReady !== 1'b1 || oCol !== 7'd0 || oRow !== 7'd0) begin
      miscompares++;
      $display("FAIL full_start: got busy=%b rdy=%b col=%0d row=%0d want 1 1 0 0", oBusy, oReady, oCol, oRow);
    end
    for (int n = 0; n < NPIX; n++) begin
      int c;
      int r;
      c = n % IMG_W;
      r = n / IMG_W;
      iValid = 1'b1;
      iData = 8'((r + c) & 255);
      ref_mem[n] = iData;
      tick();
      vectors++;
      if (n < NPIX - 1) begin
        if (oDone !== 1'b0 || oCol !== 7'((n + 1) % IMG_W) || oRow !== 7'((n + 1) / IMG_W)) begin
          miscompares++;
          $display("FAIL full_step n=%0d: got done=%b col=%0d row=%0d want 0 %0d %0d",
                   n, oDone, oCol, oRow, (n + 1) % IMG_W, (n + 1) / IMG_W);
        end
      end else if (oDone !== 1'b1 || oBusy !== 1'b0 || oCol !== 7'd0 || oRow !== 7'd0) begin
        miscompares++;
        $display("FAIL full_done: got done=%b busy=%b col=%0d row=%0d want 1 0 0 0", oDone, oBusy, oCol, oRow);
      end
    end
    iValid = 1'b0;
    tick();
    vectors++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_done_pulse: got done=%b busy=%b want 0 0", oDone, oBusy);
    end
    read_pix(5, 3, d);
    vectors++;
    if (d !== 8'h08) begin
      miscompares++;
      $display("FAIL full_rd_5_3: got %h want 08", d);
    end
    read_pix(127, 127, d);
    vectors++;
    if (d !== 8'hFE) begin
      miscompares++;
      $display("FAIL full_rd_127_127: got %h want fe", d);
    end
    for (int k = 0; k < 8; k++) begin
      int a;
      a = int'($urandom_range(0, NPIX - 1));
      read_pix(a % IMG_W, a / IMG_W, d);
      vectors++;
      if (d !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL full_rd_rand addr=%0d: got %h want %h", a, d, ref_mem[a]);
      end
    end
    $display("test_full_frame done");
  endtask

  task automatic test_drop();
    logic [7:0] d;
    iValid = 1'b1;
    iData = 8'hAA;
    tick();
    iValid = 1'b0;
    vectors++;
    if (oDropped !== 1'b1 || oReady !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_flag: got drop=%b rdy=%b want 1 0", oDropped, oReady);
    end
    read_pix(0, 0, d);
    vectors++;
    if (d !== ref_mem[0] || oDropped !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_nowrite: got rd=%h drop=%b want %h 1", d, oDropped, ref_mem[0]);
    end
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    vectors++;
    if (oDropped !== 1'b0 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_clear: got drop=%b busy=%b want 0 1", oDropped, oBusy);
    end
    do_reset();
    $display("test_drop done");
  endtask

  task automatic test_gaps();
    int n;
    n = 0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int k = 0; k < 256; k++) begin
      iValid = (k % 2 == 0);
      iData = 8'($urandom);
      if (iValid) ref_mem[n] = iData;
      tick();
      if (iValid) n++;
      vectors++;
      if (oCol !== 7'(n % IMG_W) || oRow !== 7'(n / IMG_W)) begin
        miscompares++;
        $display("FAIL gaps_step k=%0d: got col=%0d row=%0d want %0d %0d", k, oCol, oRow, n % IMG_W, n / IMG_W);
      end
    end
    iValid = 1'b0;
    vectors++;
    if (oCol !== 7'd0 || oRow !== 7'd1 || oBusy !== 1'b1) begin
      miscompares++;
      $display("FAIL gaps_wrap: got col=%0d row=%0d busy=%b want 0 1 1", oCol, oRow, oBusy);
    end
    do_reset();
    $display("test_gaps done");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int n = 0; n < 200; n++) begin
      iValid = 1'b1;
      iData = 8'($urandom);
      ref_mem[n] = iData;
      tick();
    end
    iValid = 1'b0;
    reset_n = 1'b0;
    #2;
    vectors++;
    if (oBusy !== 1'b0 || oReady !== 1'b0 || oCol !== 7'd0 || oRow !== 7'd0 || oDone !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: got busy=%b rdy=%b col=%0d row=%0d done=%b want 0 0 0 0 0",
               oBusy, oReady, oCol, oRow, oDone);
    end
    reset_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_idle: got busy=%b want 0", oBusy);
    end
    read_pix(199 % IMG_W, 199 / IMG_W, d);
    vectors++;
    if (d !== ref_mem[199]) begin
      miscompares++;
      $display("FAIL midreset_persist: got %h want %h", d, ref_mem[199]);
    end
    $display("test_reset_mid_frame done");
  endtask

  task automatic test_read_during_write();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      iValid = 1'b1;
      iData = (n == 10) ? 8'h11 : 8'($urandom);
      ref_mem[n] = iData;
      tick();
    end
    iValid = 1'b0;
    do_reset();
    tick();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int n = 0; n < 10; n++) begin
      iValid = 1'b1;
      iData = 8'($urandom);
      ref_mem[n] = iData;
      tick();
    end
    iValid = 1'b1;
    iData = 8'h55;
    iRdCol = 7'd10;
    iRdRow = 7'd0;
    tick();
    iValid = 1'b0;
    vectors++;
    if (oRdData !== 8'h11) begin
      miscompares++;
      $display("FAIL rdw_old: got %h want 11", oRdData);
    end
    ref_mem[10] = 8'h55;
    tick();
    vectors++;
    if (oRdData !== ref_mem[10]) begin
      miscompares++;
      $display("FAIL rdw_new: got %h want %h", oRdData, ref_mem[10]);
    end
    do_reset();
    $display("test_read_during_write done");
  endtask

  task automatic test_start_ignored();
    iStart = 1'b1;
    tick();
    for (int n = 0; n < NPIX; n++) begin
      iStart = (n == 500) || ($urandom_range(0, 63) == 0);
      iValid = 1'b1;
      iData = 8'($urandom);
      ref_mem[n] = iData;
      tick();
      vectors++;
      if (n < NPIX - 1) begin
        if (oDone !== 1'b0 || oCol !== 7'((n + 1) % IMG_W) || oRow !== 7'((n + 1) / IMG_W)) begin
          miscompares++;
          $display("FAIL ignstart_step n=%0d: got done=%b col=%0d row=%0d want 0 %0d %0d",
                   n, oDone, oCol, oRow, (n + 1) % IMG_W, (n + 1) / IMG_W);
        end
      end else if (oDone !== 1'b1) begin
        miscompares++;
        $display("FAIL ignstart_done: got done=%b want 1", oDone);
      end
    end
    iValid = 1'b0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    vectors++;
    if (oDone !== 1'b0 || oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignstart_in_done: got done=%b busy=%b want 0 0", oDone, oBusy);
    end
    tick();
    vectors++;
    if (oBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignstart_stay_idle: got busy=%b want 0", oBusy);
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    vectors++;
    if (oBusy !== 1'b1 || oCol !== 7'd0 || oRow !== 7'd0) begin
      miscompares++;
      $display("FAIL b2b_restart: got busy=%b col=%0d row=%0d want 1 0 0", oBusy, oCol, oRow);
    end
    for (int k = 0; k < 16; k++) begin
      int a;
      a = int'($urandom_range(0, NPIX - 1));
      read_pix(a % IMG_W, a / IMG_W, d);
      vectors++;
      if (d !== ref_mem[a]) begin
        miscompares++;
        $display("FAIL b2b_rd addr=%0d: got %h want %h", a, d, ref_mem[a]);
      end
    end
    do_reset();
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_drop();
    test_gaps();
    test_reset_mid_frame();
    test_read_during_write();
    test_start_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
